// File: rtl/bit_stuffer.sv
//==============================================================================
// Module   : bit_stuffer
// Purpose  : Serial bit stuffer. Inserts a 0 after MAX_ONES consecutive 1s,
//            stalls the encoder while it inserts, and appends an EOP window.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module bit_stuffer #(
   parameter int MAX_ONES = 6,
   parameter int EOP_LEN  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       endr,
   input  logic       s_in,
   output logic       pause,
   output logic       out_bit,
   output logic       out_valid,
   output logic       out_stuffed,
   output logic       out_eop,
   output logic [7:0] stuff_cnt,
   output logic       proto_err
);

   localparam int OW = $clog2(MAX_ONES + 1);
   localparam int EW = (EOP_LEN > 1) ? $clog2(EOP_LEN) : 1;
   localparam logic [OW-1:0] c_MAX_ONES = OW'(MAX_ONES);
   localparam logic [EW-1:0] c_EOP_LAST = EW'(EOP_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_STUFF  = 2'd2,
      S_EOP    = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [OW-1:0] r_ones_cnt;
   logic [OW-1:0] w_ones_inc;
   logic [EW-1:0] r_eop_cnt;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_ones_inc = r_ones_cnt + OW'(1);
      case (r_state)
         S_IDLE:   if (start) w_next = S_ACTIVE;
         S_ACTIVE: begin
            if (endr)                                w_next = S_EOP;
            else if (s_in && w_ones_inc == c_MAX_ONES) w_next = S_STUFF;
         end
         // An owed stuff bit always goes out before the EOP window.
         S_STUFF:  w_next = endr ? S_EOP : S_ACTIVE;
         S_EOP:    if (r_eop_cnt == c_EOP_LAST) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   assign pause = (r_state == S_STUFF) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ones_cnt  <= '0;
         r_eop_cnt   <= '0;
         out_bit     <= 1'b0;
         out_valid   <= 1'b0;
         out_stuffed <= 1'b0;
         out_eop     <= 1'b0;
         stuff_cnt   <= 8'd0;
         proto_err   <= 1'b0;
      end else begin
         out_valid   <= 1'b0;
         out_stuffed <= 1'b0;
         out_eop     <= 1'b0;
         proto_err   <= start && (r_state != S_IDLE);
         case (r_state)
            S_IDLE: begin
               r_eop_cnt <= '0;
               if (start) begin
                  r_ones_cnt <= '0;
                  stuff_cnt  <= 8'd0;
               end
            end
            S_ACTIVE: begin
               if (endr) begin
                  r_eop_cnt <= '0;
               end else begin
                  out_bit    <= s_in;
                  out_valid  <= 1'b1;
                  r_ones_cnt <= s_in ? w_ones_inc : '0;
               end
            end
            S_STUFF: begin
               out_bit     <= 1'b0;
               out_valid   <= 1'b1;
               out_stuffed <= 1'b1;
               r_ones_cnt  <= '0;
               r_eop_cnt   <= '0;
               if (stuff_cnt != 8'hFF) stuff_cnt <= stuff_cnt + 8'd1;
            end
            S_EOP: begin
               out_eop   <= 1'b1;
               r_eop_cnt <= r_eop_cnt + EW'(1);
            end
            default: r_eop_cnt <= '0;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bit_stuffer.sv
//==============================================================================
// Module   : tb_bit_stuffer
// Purpose  : Randomized and directed self-checking bench for bit_stuffer.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_bit_stuffer;

   localparam int MAX_ONES = 6;
   localparam int EOP_LEN  = 3;

   logic       clk = 1'b0;
   logic       rst, start, endr, s_in;
   logic       pause, out_bit, out_valid, out_stuffed, out_eop, proto_err;
   logic [7:0] stuff_cnt;

   bit_stuffer #(.MAX_ONES(MAX_ONES), .EOP_LEN(EOP_LEN)) dut (
      .clk(clk), .rst(rst), .start(start), .endr(endr), .s_in(s_in),
      .pause(pause), .out_bit(out_bit), .out_valid(out_valid),
      .out_stuffed(out_stuffed), .out_eop(out_eop),
      .stuff_cnt(stuff_cnt), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   bit         pkt[$];
   logic [1:0] exp_q[$];          // {bit, stuffed}
   int         exp_stuffs;
   int         valid_seen, eop_seen, pause_seen;
   logic       prev_pause = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: walk the source bits, emit each, append a stuffed 0 whenever the run of 1s hits MAX_ONES.
   task automatic build_model();
      int run;
      run = 0;
      exp_stuffs = 0;
      exp_q.delete();
      foreach (pkt[i]) begin
         exp_q.push_back({pkt[i], 1'b0});
         run = pkt[i] ? run + 1 : 0;
         if (run == MAX_ONES) begin
            exp_q.push_back(2'b01);
            exp_stuffs++;
            run = 0;
         end
      end
   endtask

   task automatic push_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) pkt.push_back(v[i]);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_pause = 1'b0;
      end else begin
         if (out_valid) begin
            valid_seen++;
            if (exp_q.size() == 0) chk("extra_valid", 32'd1, 32'd0);
            else                   chk("bit_stuffed", {30'd0, out_bit, out_stuffed}, {30'd0, exp_q.pop_front()});
         end
         if (out_eop) begin
            eop_seen++;
            chk("eop_after_bits", {exp_q.size(), out_valid}, 32'd0);
         end
         chk("stuffed_follows_pause", {31'd0, out_stuffed}, {31'd0, prev_pause});
         if (pause) pause_seen++;
         prev_pause = pause;
      end
   end

   task automatic run_packet(input int inject_at, input int rst_at);
      int  idx, cyc;
      bit  inj, done_inj;
      logic p;
      build_model();
      valid_seen = 0; eop_seen = 0; pause_seen = 0;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; endr = 1'b0;
      chk("stuff_cnt_cleared", {24'd0, stuff_cnt}, 32'd0);
      idx = 0; cyc = 0; done_inj = 0;
      while (idx < pkt.size() && cyc < 4 * pkt.size() + 10) begin
         if (idx == rst_at) begin
            rst = 1'b1;
            @(posedge clk); #1;
            chk("midrst_outs", {out_bit, out_valid, out_stuffed, out_eop, proto_err, pause, stuff_cnt}, 32'd0);
            rst = 1'b0;
            exp_q.delete();
            return;
         end
         s_in = pkt[idx];
         inj  = (idx == inject_at) && !done_inj;
         if (inj) done_inj = 1;
         start = inj;
         @(negedge clk) p = pause;
         @(posedge clk); #1;
         start = 1'b0;
         chk("proto_err", {31'd0, proto_err}, {31'd0, inj});
         if (!p) idx++;
         cyc++;
      end
      if (idx < pkt.size()) chk("bits_timeout", idx, pkt.size());
      endr = 1'b1;
      cyc = 0;
      while (eop_seen < EOP_LEN && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("eop_cycles", eop_seen, EOP_LEN);
      @(posedge clk); #1;
      chk("idle_quiet", {out_valid, out_eop, pause}, 3'd0);
      chk("all_bits_out", exp_q.size(), 32'd0);
      chk("stuff_cnt", {24'd0, stuff_cnt}, (exp_stuffs > 255) ? 32'd255 : exp_stuffs);
      chk("pause_cycles", pause_seen, exp_stuffs);
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; endr = 1'b0; s_in = 1'b0;
      @(negedge clk);
      chk("pause_in_rst", {31'd0, pause}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", {out_bit, out_valid, out_stuffed, out_eop, proto_err, pause, stuff_cnt}, 32'd0);
      rst = 1'b0;

      // SYNC + 0xD2: no stuffing
      pkt.delete(); push_byte(8'h80); push_byte(8'hD2);
      run_packet(-1, -1);
      chk("t1_valid", valid_seen, 16);
      chk("t1_stuff", {24'd0, stuff_cnt}, 0);

      // SYNC + 0xFF: one stuff after SYNC 1 + five payload 1s
      pkt.delete(); push_byte(8'h80); push_byte(8'hFF);
      run_packet(-1, -1);
      chk("t2_valid", valid_seen, 17);
      chk("t2_stuff", {24'd0, stuff_cnt}, 1);

      // 0 then twelve 1s
      pkt.delete(); pkt.push_back(1'b0);
      repeat (12) pkt.push_back(1'b1);
      run_packet(-1, -1);
      chk("t3_valid", valid_seen, 15);
      chk("t3_pause", pause_seen, 2);

      // Last bit completes a run while endr rises
      pkt.delete(); pkt.push_back(1'b0);
      repeat (6) pkt.push_back(1'b1);
      run_packet(-1, -1);
      chk("t4_valid", valid_seen, 8);
      chk("t4_stuff", {24'd0, stuff_cnt}, 1);

      // Reset mid-packet with four 1s accumulated, then a clean packet
      pkt.delete(); pkt.push_back(1'b0);
      repeat (6) pkt.push_back(1'b1);
      run_packet(-1, 5);
      pkt.delete(); push_byte(8'h80); push_byte(8'hFF);
      run_packet(-1, -1);
      chk("t5_stuff", {24'd0, stuff_cnt}, 1);

      // Spurious start mid-packet
      pkt.delete(); push_byte(8'h80); push_byte(8'hFE); push_byte(8'h3F);
      run_packet(9, -1);

      for (int k = 0; k < 25; k++) begin
         pkt.delete();
         n = $urandom_range(1, 40);
         for (int i = 0; i < n; i++) pkt.push_back($urandom_range(0, 3) != 0);
         run_packet(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1, -1);
      end

      // Saturation: 260 stuffs
      pkt.delete();
      repeat (1560) pkt.push_back(1'b1);
      run_packet(-1, -1);
      chk("sat_stuff", {24'd0, stuff_cnt}, 255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
